// File: rtl/lsu_ctrl.sv
// milano LSU controller: req/gnt/rvalid data bus master, store lane
// alignment, load extension, watchdog and pipeline stall generation.
package milano_pkg;
  typedef enum logic [3:0] {
    LSU_NONE,
    LSU_LB,
    LSU_LH,
    LSU_LW,
    LSU_LBU,
    LSU_LHU,
    LSU_SB,
    LSU_SH,
    LSU_SW
  } lsu_opt_e;
endpackage

// Ports: clk_i/rst_i (sync, active high); lsu_* request from decode/EX;
// data_* memory bus; wb_* load writeback; misaligned/err pulses; busy stall.
module lsu_ctrl
  import milano_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  lsu_opt_e    lsu_operate_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  lsu_rd_addr_i,
  output logic        lsu_busy_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_rdata_o,
  output logic        lsu_misaligned_o,
  output logic        lsu_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

  state_e         state;
  logic [CNT_W-1:0] wd_cnt;
  lsu_opt_e       op_q;
  logic           we_q;
  logic [1:0]     off_q;
  logic [4:0]     rd_q;

  logic        sz_b, sz_h, sz_w;
  logic        op_vld, aligned;
  logic [1:0]  off;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic        timeout;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  assign off    = lsu_addr_i[1:0];
  assign op_vld = lsu_req_i & (lsu_operate_i != LSU_NONE);

  always_comb begin
    sz_b = 1'b0;
    sz_h = 1'b0;
    sz_w = 1'b0;
    unique case (lsu_operate_i)
      LSU_LB, LSU_LBU, LSU_SB: sz_b = 1'b1;
      LSU_LH, LSU_LHU, LSU_SH: sz_h = 1'b1;
      LSU_LW, LSU_SW:          sz_w = 1'b1;
      default: ;
    endcase
  end

  assign aligned = sz_w ? (off == 2'b00) :
                   sz_h ? ~off[0] : 1'b1;

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = lsu_wdata_i;
    unique case (1'b1)
      sz_b: begin
        be_n    = 4'b0001 << off;
        wdata_n = {4{lsu_wdata_i[7:0]}};
      end
      sz_h: begin
        be_n    = off[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{lsu_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Fires in the last WAIT cycle the watchdog allows.
  assign timeout = (TIMEOUT_CYCLES != 0) && (state == WAIT) &&
                   !data_rvalid_i &&
                   (({1'b0, wd_cnt} + 1'b1) == TO_LIM);

  assign lsu_busy_o = ((state == IDLE) & op_vld & aligned) |
                      (state == REQ) |
                      ((state == WAIT) & ~data_rvalid_i & ~timeout);

  assign ld_b = data_rdata_i[{off_q, 3'b000} +: 8];
  assign ld_h = data_rdata_i[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = data_rdata_i;
    unique case (op_q)
      LSU_LB:  ld_ext = {{24{ld_b[7]}}, ld_b};
      LSU_LBU: ld_ext = {24'd0, ld_b};
      LSU_LH:  ld_ext = {{16{ld_h[15]}}, ld_h};
      LSU_LHU: ld_ext = {16'd0, ld_h};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      wd_cnt           <= '0;
      op_q             <= LSU_NONE;
      we_q             <= 1'b0;
      off_q            <= 2'b00;
      rd_q             <= 5'd0;
      data_req_o       <= 1'b0;
      data_addr_o      <= 32'd0;
      data_we_o        <= 1'b0;
      data_be_o        <= 4'd0;
      data_wdata_o     <= 32'd0;
      wb_valid_o       <= 1'b0;
      wb_rd_addr_o     <= 5'd0;
      wb_rdata_o       <= 32'd0;
      lsu_misaligned_o <= 1'b0;
      lsu_err_o        <= 1'b0;
    end else begin
      wb_valid_o       <= 1'b0;
      lsu_misaligned_o <= 1'b0;
      lsu_err_o        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (op_vld) begin
            if (aligned) begin
              op_q         <= lsu_operate_i;
              we_q         <= lsu_we_i;
              off_q        <= off;
              rd_q         <= lsu_rd_addr_i;
              data_req_o   <= 1'b1;
              data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
              data_we_o    <= lsu_we_i;
              data_be_o    <= be_n;
              data_wdata_o <= wdata_n;
              state        <= REQ;
            end else begin
              lsu_misaligned_o <= 1'b1;
            end
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (data_rvalid_i) begin
            state  <= IDLE;
            wd_cnt <= '0;
            if (data_err_i) begin
              lsu_err_o <= 1'b1;
            end else if (!we_q) begin
              wb_valid_o   <= 1'b1;
              wb_rd_addr_o <= rd_q;
              wb_rdata_o   <= ld_ext;
            end
          end else if (timeout) begin
            state     <= IDLE;
            wd_cnt    <= '0;
            lsu_err_o <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed vector table, reset-in-WAIT
// sequence and randomized transactions against a transaction-level model.
module tb_lsu_ctrl;
  import milano_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we;
  lsu_opt_e    lsu_op;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [4:0]  lsu_rd;
  logic        busy;
  logic        d_req, d_gnt, d_we, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        wb_valid, mis, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we),
    .lsu_operate_i(lsu_op), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_rd_addr_i(lsu_rd),
    .lsu_busy_o(busy),
    .data_req_o(d_req), .data_gnt_i(d_gnt),
    .data_addr_o(d_addr), .data_we_o(d_we),
    .data_be_o(d_be), .data_wdata_o(d_wdata),
    .data_rvalid_i(d_rvalid), .data_rdata_i(d_rdata),
    .data_err_i(d_err),
    .wb_valid_o(wb_valid), .wb_rd_addr_o(wb_rd),
    .wb_rdata_o(wb_rdata),
    .lsu_misaligned_o(mis), .lsu_err_o(err)
  );

  typedef struct {
    lsu_opt_e    op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          gnt_dly;
    int          rv_dly;
    logic        berr;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_wb;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_store(input lsu_opt_e op);
    return op == LSU_SB || op == LSU_SH || op == LSU_SW;
  endfunction

  function automatic int op_bytes(input lsu_opt_e op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: return 1;
      LSU_LH, LSU_LHU, LSU_SH: return 2;
      default:                 return 4;
    endcase
  endfunction

  // Reference: derives all expectations from address arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int sz, o;
    logic [31:0] w;
    r  = v;
    sz = op_bytes(v.op);
    o  = int'(v.addr % 4);
    r.exp_mis   = (v.addr % sz) != 0;
    r.exp_be    = 4'(((1 << sz) - 1) << o);
    r.exp_wdata = (sz == 1) ? (v.wdata & 32'hFF) * 32'h0101_0101 :
                  (sz == 2) ? (v.wdata & 32'hFFFF) * 32'h0001_0001 :
                  v.wdata;
    w = v.rdata >> (8 * o);
    case (v.op)
      LSU_LB:  r.exp_rdata = (w & 32'h80) != 0 ?
                             (w & 32'hFF) | 32'hFFFF_FF00 : w & 32'hFF;
      LSU_LBU: r.exp_rdata = w & 32'hFF;
      LSU_LH:  r.exp_rdata = (w & 32'h8000) != 0 ?
                             (w & 32'hFFFF) | 32'hFFFF_0000 : w & 32'hFFFF;
      LSU_LHU: r.exp_rdata = w & 32'hFFFF;
      default: r.exp_rdata = v.rdata;
    endcase
    if (r.exp_mis) begin
      r.exp_wb  = 1'b0;
      r.exp_err = 1'b0;
    end else if (v.rv_dly >= TO) begin
      r.exp_wb  = 1'b0;
      r.exp_err = 1'b1;
    end else begin
      r.exp_err = v.berr;
      r.exp_wb  = !v.berr && !is_store(v.op);
    end
    return r;
  endfunction

  task automatic run(input vec_t v);
    int last;
    @(negedge clk);
    lsu_req   = 1'b1;
    lsu_op    = v.op;
    lsu_we    = is_store(v.op);
    lsu_addr  = v.addr;
    lsu_wdata = v.wdata;
    lsu_rd    = v.rd;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    #1 chk("busy_accept", 32'(busy), 32'(!v.exp_mis));
    @(negedge clk);
    chk("misaligned", 32'(mis), 32'(v.exp_mis));
    if (v.exp_mis) begin
      lsu_req = 1'b0;
      chk("req_mis", 32'(d_req), 0);
      @(negedge clk);
      chk("mis_pulse", 32'(mis), 0);
      chk("req_mis2", 32'(d_req), 0);
      return;
    end
    for (int i = 0; i <= v.gnt_dly; i++) begin
      if (i > 0) @(negedge clk);
      d_gnt    = (i == v.gnt_dly);
      d_rvalid = (i != v.gnt_dly) && ($urandom_range(1) == 1);
      d_err    = 1'($urandom_range(1));
      d_rdata  = $urandom;
      chk("data_req", 32'(d_req), 1);
      chk("data_addr", d_addr, v.addr & 32'hFFFF_FFFC);
      chk("data_be", 32'(d_be), 32'(v.exp_be));
      chk("data_we", 32'(d_we), 32'(is_store(v.op)));
      if (is_store(v.op)) chk("data_wdata", d_wdata, v.exp_wdata);
      #1 chk("busy_req", 32'(busy), 1);
    end
    @(negedge clk);
    d_gnt    = 1'b0;
    d_rvalid = 1'b0;
    chk("req_drop", 32'(d_req), 0);
    last = (v.rv_dly < TO) ? v.rv_dly : TO - 1;
    for (int w = 0; w <= last; w++) begin
      if (w > 0) @(negedge clk);
      if (w == last) begin
        lsu_req = 1'b0;
        if (v.rv_dly < TO) begin
          d_rvalid = 1'b1;
          d_err    = v.berr;
          d_rdata  = v.rdata;
        end
        #1 chk("busy_end", 32'(busy), 0);
      end else begin
        #1 chk("busy_wait", 32'(busy), 1);
      end
    end
    @(negedge clk);
    d_rvalid = 1'b0;
    chk("wb_valid", 32'(wb_valid), 32'(v.exp_wb));
    chk("lsu_err", 32'(err), 32'(v.exp_err));
    if (v.exp_wb) begin
      chk("wb_rd", 32'(wb_rd), 32'(v.rd));
      chk("wb_rdata", wb_rdata, v.exp_rdata);
    end
    @(negedge clk);
    chk("wb_pulse", 32'(wb_valid), 0);
    chk("err_pulse", 32'(err), 0);
  endtask

  function automatic vec_t mk(input lsu_opt_e op, input logic [31:0] a,
                              input logic [31:0] wd, input logic [4:0] rd,
                              input int g, input int rv, input logic be,
                              input logic [31:0] rdat, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic ewb,
                              input logic [31:0] erd, input logic emis,
                              input logic eerr);
    vec_t v;
    v.op = op; v.addr = a; v.wdata = wd; v.rd = rd;
    v.gnt_dly = g; v.rv_dly = rv; v.berr = be; v.rdata = rdat;
    v.exp_be = ebe; v.exp_wdata = ewd; v.exp_wb = ewb;
    v.exp_rdata = erd; v.exp_mis = emis; v.exp_err = eerr;
    return v;
  endfunction

  vec_t tbl[$];
  vec_t rv;

  initial begin
    tbl.push_back(mk(LSU_LB,  32'h1003, 0, 5, 0, 0, 0, 32'h80FF_1234,
                     4'b1000, 0, 1, 32'hFFFF_FF80, 0, 0));
    tbl.push_back(mk(LSU_LBU, 32'h1003, 0, 6, 0, 0, 0, 32'h80FF_1234,
                     4'b1000, 0, 1, 32'h0000_0080, 0, 0));
    tbl.push_back(mk(LSU_SH, 32'h2002, 32'hDEAD_BEEF, 0, 3, 1, 0, 0,
                     4'b1100, 32'hBEEF_BEEF, 0, 0, 0, 0));
    tbl.push_back(mk(LSU_LW, 32'h3001, 0, 1, 0, 0, 0, 0,
                     4'b1111, 0, 0, 0, 1, 0));
    tbl.push_back(mk(LSU_LW, 32'h4000, 0, 2, 1, 0, 1, 32'h1111_2222,
                     4'b1111, 0, 0, 0, 0, 1));
    tbl.push_back(mk(LSU_LW, 32'h5000, 0, 3, 0, 6, 0, 0,
                     4'b1111, 0, 0, 0, 0, 1));
    tbl.push_back(mk(LSU_LH, 32'h6002, 0, 4, 0, 0, 0, 32'h8001_7FFF,
                     4'b1100, 0, 1, 32'hFFFF_8001, 0, 0));
    tbl.push_back(mk(LSU_LHU, 32'h6000, 0, 8, 2, 2, 0, 32'h8001_F00D,
                     4'b0011, 0, 1, 32'h0000_F00D, 0, 0));
    tbl.push_back(mk(LSU_SB, 32'h7001, 32'h1234_56A5, 0, 0, 0, 0, 0,
                     4'b0010, 32'hA5A5_A5A5, 0, 0, 0, 0));
    tbl.push_back(mk(LSU_SW, 32'h8000, 32'hCAFE_F00D, 0, 1, 3, 0, 0,
                     4'b1111, 32'hCAFE_F00D, 0, 0, 0, 0));
    tbl.push_back(mk(LSU_LH, 32'h6001, 0, 1, 0, 0, 0, 0,
                     4'b0000, 0, 0, 0, 1, 0));
    tbl.push_back(mk(LSU_SH, 32'h2003, 0, 1, 0, 0, 0, 0,
                     4'b0000, 0, 0, 0, 1, 0));
    tbl.push_back(mk(LSU_LB, 32'h9002, 0, 0, 0, 0, 0, 32'h0045_0000,
                     4'b0100, 0, 1, 32'h0000_0045, 0, 0));

    rst = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; lsu_op = LSU_NONE;
    lsu_addr = 0; lsu_wdata = 0; lsu_rd = 0;
    d_gnt = 1'b0; d_rvalid = 1'b0; d_err = 1'b0; d_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(d_req), 0);
    chk("rst_wb", 32'(wb_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mis", 32'(mis), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    foreach (tbl[i]) run(tbl[i]);

    // Reset during WAIT, then a stray response.
    @(negedge clk);
    lsu_req = 1'b1; lsu_op = LSU_LW; lsu_we = 1'b0;
    lsu_addr = 32'hA000; lsu_rd = 5'd7;
    @(negedge clk);
    d_gnt = 1'b1;
    @(negedge clk);
    d_gnt = 1'b0;
    #1 chk("rst_seq_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_req", 32'(d_req), 0);
    chk("rstw_addr", d_addr, 0);
    chk("rstw_be", 32'(d_be), 0);
    chk("rstw_wb_rd", 32'(wb_rd), 0);
    chk("rstw_wb_rdata", wb_rdata, 0);
    chk("rstw_err", 32'(err), 0);
    rst = 1'b0; lsu_req = 1'b0;
    d_rvalid = 1'b1; d_err = 1'b0; d_rdata = 32'hFFFF_FFFF;
    #1 chk("rstw_busy", 32'(busy), 0);
    @(negedge clk);
    d_rvalid = 1'b0;
    chk("stray_wb", 32'(wb_valid), 0);
    chk("stray_err", 32'(err), 0);
    chk("stray_req", 32'(d_req), 0);

    for (int n = 0; n < 150; n++) begin
      rv = mk(LSU_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.op      = lsu_opt_e'($urandom_range(8, 1));
      rv.addr    = $urandom;
      rv.wdata   = $urandom;
      rv.rd      = 5'($urandom_range(31));
      rv.gnt_dly = $urandom_range(3);
      rv.rv_dly  = $urandom_range(5);
      rv.berr    = ($urandom_range(7) == 0);
      rv.rdata   = $urandom;
      run(model(rv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
